cache_refill_ctrl: RTL and testbench

Miss-handling and refill controller for the 128-byte direct-mapped cache, sitting between the CPU and the cache/main-memory pair. It drives the cache's lookup side (address, w_rd) and acts on the cache's hit response. On a read miss it fetches the byte from main memory, writes it into the cache and returns it to the CPU. Write policy is write-through: every CPU write updates both the cache and memory.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_stat_cnt.sv | 27 ++
 rtl/cache_refill_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants, state encoding and cache write/read strobe values.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int INDEX_W = 7;
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int CNT_W   = 16;

  // Polarity of the cache w_rd strobe.
  localparam logic W_RD_READ  = 1'b0;
  localparam logic W_RD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MISS_WAIT,
    FILL,
    WR_BOTH,
    DONE
  } state_t;

endpackage

// File: rtl/cache_stat_cnt.sv
// Saturating event counter with synchronous clear.
// Latency: count visible one cycle after the increment strobe.
// Backpressure: none; clear takes priority over increment and the count sticks at all-ones.
module cache_stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Clear wins over increment; stop at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill and write-through controller between CPU, cache and main memory.
// Latency: read hit 3 cycles, read miss 4 + memory wait cycles, write ready one cycle after mem_ack.
// Backpressure: CPU request held until cpu_ready; mem_req held until mem_ack. Optional counters: CACHE_STATS_EN.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic              clk_1,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cache_w_rd,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_hits,
  output logic [CNT_W-1:0]  stat_misses,
  output logic [CNT_W-1:0]  stat_writes
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] cpu_rdata_d;
  logic              cpu_ready_d;
  logic              cache_w_rd_d;
  logic [ADDR_W-1:0] cache_addr_d;
  logic [DATA_W-1:0] cache_wdata_d;
  logic              mem_req_d;
  logic              mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // State and every output are registered; reset aborts any transaction in flight.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      fill_q      <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cache_w_rd  <= W_RD_READ;
      cache_addr  <= '0;
      cache_wdata <= '0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fill_q      <= fill_d;
      cpu_rdata   <= cpu_rdata_d;
      cpu_ready   <= cpu_ready_d;
      cache_w_rd  <= cache_w_rd_d;
      cache_addr  <= cache_addr_d;
      cache_wdata <= cache_wdata_d;
      mem_req     <= mem_req_d;
      mem_wr      <= mem_wr_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

  // Next state and next output values; registers hold unless a state says otherwise.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    fill_d        = fill_q;
    cpu_rdata_d   = cpu_rdata;
    cpu_ready_d   = 1'b0;
    cache_w_rd_d  = cache_w_rd;
    cache_addr_d  = cache_addr;
    cache_wdata_d = cache_wdata;
    mem_req_d     = mem_req;
    mem_wr_d      = mem_wr;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d       = cpu_addr;
          cache_addr_d = cpu_addr;
          if (cpu_wr) begin
            // Write-through: cache and memory are written from the same latched request.
            cache_w_rd_d  = W_RD_WRITE;
            cache_wdata_d = cpu_wdata;
            mem_req_d     = 1'b1;
            mem_wr_d      = 1'b1;
            mem_addr_d    = cpu_addr;
            mem_wdata_d   = cpu_wdata;
            state_d       = WR_BOTH;
          end else begin
            cache_w_rd_d = W_RD_READ;
            state_d      = LOOKUP;
          end
        end
      end

      // The cache registers the lookup; its hit flag is only valid in CHECK.
      LOOKUP: state_d = CHECK;

      CHECK: begin
        // An unknown hit flag falls into the miss branch, which is always safe.
        if (cache_hit) begin
          cpu_rdata_d = cache_rdata;
          cpu_ready_d = 1'b1;
          state_d     = DONE;
        end else begin
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = addr_q;
          state_d    = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        if (mem_ack) begin
          fill_d        = mem_rdata;
          mem_req_d     = 1'b0;
          cache_w_rd_d  = W_RD_WRITE;
          cache_wdata_d = mem_rdata;
          state_d       = FILL;
        end
      end

      FILL: begin
        cache_w_rd_d = W_RD_READ;
        cpu_rdata_d  = fill_q;
        cpu_ready_d  = 1'b1;
        state_d      = DONE;
      end

      WR_BOTH: begin
        // Cache write lasts exactly the first cycle; memory side waits for the ack.
        cache_w_rd_d = W_RD_READ;
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_wr_d    = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic inc_hit, inc_miss, inc_write;

  // Event strobes taken from the same decisions the FSM makes.
  always_comb begin
    inc_hit   = (state_q == CHECK) && cache_hit;
    inc_miss  = (state_q == CHECK) && !cache_hit;
    inc_write = (state_q == IDLE) && cpu_req && cpu_wr;
  end

  cache_stat_cnt #(.W(CNT_W)) u_cnt_hits (
    .clk(clk_1), .rst(rst), .clr(stat_clr), .inc(inc_hit),   .cnt(stat_hits)
  );
  cache_stat_cnt #(.W(CNT_W)) u_cnt_misses (
    .clk(clk_1), .rst(rst), .clr(stat_clr), .inc(inc_miss),  .cnt(stat_misses)
  );
  cache_stat_cnt #(.W(CNT_W)) u_cnt_writes (
    .clk(clk_1), .rst(rst), .clr(stat_clr), .inc(inc_write), .cnt(stat_writes)
  );
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural 128-entry direct-mapped cache.
// Latency: measured in clock edges after the accept edge (edges + 1 = cycles).
// Backpressure: memory ack is issued by the bench after a per-vector delay.
module tb_cache_refill_ctrl;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        cache_w_rd;
  logic [15:0] cache_addr;
  logic [7:0]  cache_wdata, cache_rdata;
  logic        cache_hit;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_hits, stat_misses, stat_writes;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_1 = ~clk_1;

  cache_refill_ctrl dut (
    .clk_1(clk_1), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cache_w_rd(cache_w_rd), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .stat_clr(stat_clr), .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_writes(stat_writes)
`endif
  );

  // Behavioural cache: registered hit/data one edge after the address, fill on w_rd=1.
  logic       cache_init;
  logic       cv [128];
  logic [8:0] ct [128];
  logic [7:0] cd [128];
  always @(posedge clk_1) begin
    if (cache_init) begin
      for (int i = 0; i < 128; i++) cv[i] <= 1'b0;
      cv[1] <= 1'b1;
      ct[1] <= 9'h000;
      cd[1] <= 8'h03;
    end else if (cache_w_rd) begin
      cv[cache_addr[6:0]] <= 1'b1;
      ct[cache_addr[6:0]] <= cache_addr[15:7];
      cd[cache_addr[6:0]] <= cache_wdata;
    end
    cache_hit   <= cv[cache_addr[6:0]] && (ct[cache_addr[6:0]] == cache_addr[15:7]);
    cache_rdata <= cd[cache_addr[6:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"},  {28'd0, cpu_ready, cache_w_rd, mem_req, mem_wr}, 32'd0);
    chk({nm, "_data"}, {8'd0, cpu_rdata, cache_wdata, mem_wdata}, 32'd0);
    chk({nm, "_addr"}, {cache_addr, mem_addr}, 32'd0);
  endtask

  // One complete CPU transaction; the memory acks after d cycles of mem_req.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                        input int d, input logic [7:0] mdata,
                        output int lat, output logic [7:0] rdata, output logic saw_mreq,
                        output logic mwr, output logic [15:0] maddr, output logic [7:0] mwdata,
                        output int wcyc, output logic [15:0] waddr, output logic [7:0] wwdata,
                        output logic rdy_after);
    int wcnt;
    lat = -1; rdata = '0; saw_mreq = 1'b0; mwr = 1'b0; maddr = '0; mwdata = '0;
    wcyc = 0; waddr = '0; wwdata = '0; wcnt = 0;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    tick();
    // Garbage on the request inputs must be ignored mid-transaction.
    cpu_req = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hFFFF; cpu_wdata = 8'hEE;
    for (int cyc = 0; cyc < 200; cyc++) begin
      mem_ack = 1'b0;
      if (cpu_ready) begin
        lat = cyc;
        rdata = cpu_rdata;
        break;
      end
      if (cache_w_rd) begin
        wcyc++;
        waddr = cache_addr;
        wwdata = cache_wdata;
      end
      if (mem_req) begin
        if (!saw_mreq) begin
          mwr = mem_wr; maddr = mem_addr; mwdata = mem_wdata;
        end
        saw_mreq = 1'b1;
        wcnt++;
        if (wcnt == d) begin
          mem_ack = 1'b1;
          mem_rdata = mdata;
        end
      end
      tick();
    end
    mem_ack = 1'b0;
    cpu_wr = 1'b0;
    tick();
    rdy_after = cpu_ready;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          d;
    logic [7:0]  mdata;
    int          lat;
    logic [7:0]  rdata;
    logic        mreq;
  } vec_t;

  vec_t vecs[9];

  int          lat, wcyc;
  logic [7:0]  rdata, mwdata, wwdata;
  logic        saw_mreq, mwr, rdy_after;
  logic [15:0] maddr, waddr;

  initial begin
    // wr, addr, wdata, ack delay, mem data, exp latency (edges), exp rdata, exp mem_req
    vecs[0] = '{1'b0, 16'h0001, 8'h00, 0, 8'h00, 2, 8'h03, 1'b0}; // preloaded hit
    vecs[1] = '{1'b0, 16'h1234, 8'h00, 5, 8'hA5, 8, 8'hA5, 1'b1}; // miss, 5 wait cycles
    vecs[2] = '{1'b0, 16'h1234, 8'h00, 0, 8'h00, 2, 8'hA5, 1'b0}; // refilled line hits
    vecs[3] = '{1'b1, 16'hBEEF, 8'h5A, 2, 8'h00, 2, 8'h00, 1'b1}; // write, ack after 2
    vecs[4] = '{1'b0, 16'hBEEF, 8'h00, 0, 8'h00, 2, 8'h5A, 1'b0}; // written data hits
    vecs[5] = '{1'b0, 16'h0081, 8'h00, 1, 8'h3C, 4, 8'h3C, 1'b1}; // conflict miss, index 1
    vecs[6] = '{1'b0, 16'h0001, 8'h00, 3, 8'h77, 6, 8'h77, 1'b1}; // evicted -> miss
    vecs[7] = '{1'b1, 16'h0001, 8'hC3, 1, 8'h00, 1, 8'h00, 1'b1}; // write, ack in 1st cycle
    vecs[8] = '{1'b0, 16'h0001, 8'h00, 0, 8'h00, 2, 8'hC3, 1'b0}; // hit on written data

    rst = 1'b1; cache_init = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
    stat_clr = 1'b0;
`endif
    #1;
    chk_zero("reset");
    tick(); tick();
    cache_init = 1'b0;
    rst = 1'b0;
    tick();
    chk_zero("post_reset");

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].d, vecs[i].mdata,
             lat, rdata, saw_mreq, mwr, maddr, mwdata, wcyc, waddr, wwdata, rdy_after);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_mem_req", i), {31'd0, saw_mreq}, {31'd0, vecs[i].mreq});
      chk($sformatf("vec%0d_cache_wr_cycles", i), wcyc, {31'd0, vecs[i].mreq});
      chk($sformatf("vec%0d_ready_pulse", i), {31'd0, rdy_after}, 32'd0);
      if (!vecs[i].wr)
        chk($sformatf("vec%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].rdata});
      if (vecs[i].mreq) begin
        chk($sformatf("vec%0d_mem_addr", i), {16'd0, maddr}, {16'd0, vecs[i].addr});
        chk($sformatf("vec%0d_mem_wr", i), {31'd0, mwr}, {31'd0, vecs[i].wr});
        chk($sformatf("vec%0d_cache_addr", i), {16'd0, waddr}, {16'd0, vecs[i].addr});
        chk($sformatf("vec%0d_cache_wdata", i), {24'd0, wwdata},
            {24'd0, (vecs[i].wr ? vecs[i].wdata : vecs[i].mdata)});
      end
      if (vecs[i].wr)
        chk($sformatf("vec%0d_mem_wdata", i), {24'd0, mwdata}, {24'd0, vecs[i].wdata});
    end

    // Back-to-back reads with cpu_req held: ready at edges 3, 7, 11 and never two in a row.
    begin
      int first_rise, second_rise, highs;
      logic prev, merged;
      first_rise = -1; second_rise = -1; highs = 0; prev = 1'b0; merged = 1'b0;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h1234;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        tick();
        if (cpu_ready) begin
          highs++;
          if (prev) merged = 1'b1;
          if (first_rise < 0) first_rise = cyc;
          else if (second_rise < 0) second_rise = cyc;
        end
        prev = cpu_ready;
      end
      cpu_req = 1'b0;
      chk("b2b_first_ready", first_rise, 3);
      chk("b2b_second_ready", second_rise, 7);
      chk("b2b_ready_count", highs, 3);
      chk("b2b_no_merge", {31'd0, merged}, 32'd0);
      chk("b2b_rdata", {24'd0, cpu_rdata}, 32'h0000_00A5);
      tick();
    end

    // Reset while waiting on memory: outputs clear at once, late ack is ignored.
    begin
      int budget;
      logic bad_ready, bad_req, bad_wr;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h2222;
      tick();
      cpu_req = 1'b0;
      budget = 0;
      while (!mem_req && budget < 10) begin
        tick();
        budget++;
      end
      chk("abort_mem_req_seen", {31'd0, mem_req}, 32'd1);
      chk("abort_mem_addr", {16'd0, mem_addr}, 32'h0000_2222);
      tick(); tick();
      #2;
      rst = 1'b1;
      #1;
      chk_zero("abort");
      tick();
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 8'h99;
      bad_ready = 1'b0; bad_req = 1'b0; bad_wr = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        tick();
        mem_ack = 1'b0;
        if (cpu_ready) bad_ready = 1'b1;
        if (mem_req) bad_req = 1'b1;
        if (cache_w_rd) bad_wr = 1'b1;
      end
      chk("abort_no_ready", {31'd0, bad_ready}, 32'd0);
      chk("abort_no_mem_req", {31'd0, bad_req}, 32'd0);
      chk("abort_no_fill", {31'd0, bad_wr}, 32'd0);
    end

    // Controller is usable again after the abort.
    do_req(1'b0, 16'h1234, 8'h00, 0, 8'h00, lat, rdata, saw_mreq, mwr, maddr, mwdata,
           wcyc, waddr, wwdata, rdy_after);
    chk("recover_lat", lat, 2);
    chk("recover_rdata", {24'd0, rdata}, 32'h0000_00A5);

`ifdef CACHE_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr_hits", {16'd0, stat_hits}, 32'd0);
    do_req(1'b0, 16'h1234, 8'h00, 0, 8'h00, lat, rdata, saw_mreq, mwr, maddr, mwdata,
           wcyc, waddr, wwdata, rdy_after);
    do_req(1'b0, 16'hBEEF, 8'h00, 0, 8'h00, lat, rdata, saw_mreq, mwr, maddr, mwdata,
           wcyc, waddr, wwdata, rdy_after);
    do_req(1'b0, 16'h4000, 8'h00, 1, 8'h11, lat, rdata, saw_mreq, mwr, maddr, mwdata,
           wcyc, waddr, wwdata, rdy_after);
    do_req(1'b1, 16'h0002, 8'h22, 1, 8'h00, lat, rdata, saw_mreq, mwr, maddr, mwdata,
           wcyc, waddr, wwdata, rdy_after);
    chk("stat_hits", {16'd0, stat_hits}, 32'd2);
    chk("stat_misses", {16'd0, stat_misses}, 32'd1);
    chk("stat_writes", {16'd0, stat_writes}, 32'd1);
    // Clear held across a hit: the clear must beat the increment.
    stat_clr = 1'b1;
    do_req(1'b0, 16'h1234, 8'h00, 0, 8'h00, lat, rdata, saw_mreq, mwr, maddr, mwdata,
           wcyc, waddr, wwdata, rdy_after);
    stat_clr = 1'b0;
    chk("stat_clr_vs_hit", {stat_hits, stat_misses}, 32'd0);
    chk("stat_clr_writes", {16'd0, stat_writes}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
